// File: rtl/board_move_writer_pkg.sv
// Shared definitions for the chess board store: piece codes, square/code types
// and the move FSM state encoding.
package board_move_writer_pkg;

  typedef logic [5:0] sq_t;
  typedef logic [3:0] code_t;

  localparam int NUM_SQ = 64;

  localparam code_t EMPTY    = 4'h0;
  localparam code_t W_PAWN   = 4'h1;
  localparam code_t W_BISHOP = 4'h2;
  localparam code_t W_KNIGHT = 4'h3;
  localparam code_t W_ROOK   = 4'h4;
  localparam code_t W_QUEEN  = 4'h5;
  localparam code_t W_KING   = 4'h6;
  localparam code_t B_PAWN   = 4'h7;
  localparam code_t B_BISHOP = 4'h8;
  localparam code_t B_KNIGHT = 4'h9;
  localparam code_t B_ROOK   = 4'hA;
  localparam code_t B_QUEEN  = 4'hB;
  localparam code_t B_KING   = 4'hC;
  localparam code_t MARKER   = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_TO,
    ST_CLR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/board_start_rom.sv
// Combinational start-position lookup: square index -> initial piece code.
// Row 0 is rank 8 (black back rank), column 0 is file a.
module board_start_rom
  import board_move_writer_pkg::*;
(
  input  logic [5:0] sq_i,
  output logic [3:0] code_o
);

  always_comb begin
    code_o = EMPTY;
    case (sq_i[5:3])
      3'd0: begin
        case (sq_i[2:0])
          3'd0: code_o = B_ROOK;
          3'd1: code_o = B_KNIGHT;
          3'd2: code_o = B_BISHOP;
          3'd3: code_o = B_QUEEN;
          3'd4: code_o = B_KING;
          3'd5: code_o = B_BISHOP;
          3'd6: code_o = B_KNIGHT;
          3'd7: code_o = B_ROOK;
        endcase
      end
      3'd1: code_o = B_PAWN;
      3'd6: code_o = W_PAWN;
      3'd7: begin
        case (sq_i[2:0])
          3'd0: code_o = W_ROOK;
          3'd1: code_o = W_KNIGHT;
          3'd2: code_o = W_BISHOP;
          3'd3: code_o = W_QUEEN;
          3'd4: code_o = W_KING;
          3'd5: code_o = W_BISHOP;
          3'd6: code_o = W_KNIGHT;
          3'd7: code_o = W_ROOK;
        endcase
      end
      default: code_o = EMPTY;
    endcase
  end

endmodule

// File: rtl/board_move_writer.sv
// 8x8 board store with a sequenced move engine (read, write dest, clear source)
// and a 1-cycle registered read port for the figure renderer.
module board_move_writer
  import board_move_writer_pkg::*;
#(
  parameter int CODE_W = 4,
  parameter int SQ_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [SQ_W-1:0]   move_from,
  input  logic [SQ_W-1:0]   move_to,
  output logic              move_done,
  output logic              move_err,
  output logic [CODE_W-1:0] move_captured,
  input  logic [SQ_W-1:0]   rd_xy,
  output logic [CODE_W-1:0] rd_code
);

  logic [NUM_SQ-1:0][3:0] start_board;
  logic [NUM_SQ-1:0][3:0] board_q;

  state_e state_q, state_d;
  sq_t    from_q, to_q;
  code_t  piece_q, cap_q;
  logic   err_q;
  code_t  rd_code_q;

  // One ROM per square so the whole board reloads in a single edge.
  for (genvar g = 0; g < NUM_SQ; g++) begin : g_rom
    board_start_rom u_rom (
      .sq_i   (6'(g)),
      .code_o (start_board[g])
    );
  end

  logic  accept, reload, rd_bad;
  code_t from_code, to_code;

  assign accept    = move_valid && move_ready;
  assign reload    = (state_q == ST_IDLE) && new_game;
  assign from_code = board_q[from_q];
  assign to_code   = board_q[to_q];
  assign rd_bad    = (from_code == EMPTY) || (from_q == to_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RD;
      ST_RD:    state_d = rd_bad ? ST_DONE : ST_WR_TO;
      ST_WR_TO: state_d = ST_CLR;
      ST_CLR:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    move_ready    = (state_q == ST_IDLE) && !new_game;
    move_done     = (state_q == ST_DONE);
    move_err      = move_done && err_q;
    move_captured = (move_done && !err_q) ? cap_q : EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_q   <= start_board;
      from_q    <= '0;
      to_q      <= '0;
      piece_q   <= EMPTY;
      cap_q     <= EMPTY;
      err_q     <= 1'b0;
      rd_code_q <= EMPTY;
    end else begin
      if (accept) begin
        from_q <= move_from;
        to_q   <= move_to;
      end
      if (state_q == ST_RD) begin
        piece_q <= from_code;
        cap_q   <= to_code;
        err_q   <= rd_bad;
      end
      // Single write per edge; reload only happens in IDLE so never collides.
      if (reload)                   board_q         <= start_board;
      else if (state_q == ST_WR_TO) board_q[to_q]   <= piece_q;
      else if (state_q == ST_CLR)   board_q[from_q] <= EMPTY;
      rd_code_q <= board_q[rd_xy];
    end
  end

  assign rd_code = rd_code_q;

endmodule

// File: tb/tb_board_move_writer.sv
// Directed bench for board_move_writer: reset image, moves, errors, capture,
// new_game priority and reset during a move.
module tb_board_move_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       move_valid;
  logic       move_ready;
  logic [5:0] move_from;
  logic [5:0] move_to;
  logic       move_done;
  logic       move_err;
  logic [3:0] move_captured;
  logic [5:0] rd_xy;
  logic [3:0] rd_code;

  int n_chk  = 0;
  int n_fail = 0;

  board_move_writer #(.CODE_W(4), .SQ_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_game      (new_game),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_from     (move_from),
    .move_to       (move_to),
    .move_done     (move_done),
    .move_err      (move_err),
    .move_captured (move_captured),
    .rd_xy         (rd_xy),
    .rd_code       (rd_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int sq, input int exp, input string tag);
    rd_xy = 6'(sq);
    tick();
    chk(tag, int'(rd_code), exp);
  endtask

  // Issue a move and check done latency (cycles after the accept edge),
  // err/captured at done, ready low throughout, and ready back after done.
  task automatic do_move(input int f, input int t, input int lat, input int e_err,
                         input int e_cap, input string tag);
    int seen    = 0;
    int rdy_bad = 0;
    int err_v   = -1;
    int cap_v   = -1;
    chk({tag, "_rdy_pre"}, int'(move_ready), 1);
    move_valid = 1'b1;
    move_from  = 6'(f);
    move_to    = 6'(t);
    tick();
    move_valid = 1'b0;
    move_from  = 6'd63;
    move_to    = 6'd63;
    for (int c = 1; c <= 8; c++) begin
      if (move_ready) rdy_bad++;
      if (move_done && seen == 0) begin
        seen  = c;
        err_v = int'(move_err);
        cap_v = int'(move_captured);
      end
      tick();
      if (seen != 0) break;
    end
    chk({tag, "_lat"}, seen, lat);
    chk({tag, "_err"}, err_v, e_err);
    chk({tag, "_cap"}, cap_v, e_cap);
    chk({tag, "_rdy_busy"}, rdy_bad, 0);
    chk({tag, "_rdy_post"}, int'(move_ready), 1);
    chk({tag, "_done_post"}, int'(move_done), 0);
    chk({tag, "_err_post"}, int'(move_err), 0);
  endtask

  task automatic no_done(input int cycles, input string tag);
    int hits = 0;
    for (int c = 0; c < cycles; c++) begin
      if (move_done) hits++;
      tick();
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_from  = '0;
    move_to    = '0;
    rd_xy      = '0;

    tick();
    tick();
    chk("rst_done", int'(move_done), 0);
    chk("rst_err", int'(move_err), 0);
    chk("rst_cap", int'(move_captured), 0);
    chk("rst_rdcode", int'(rd_code), 0);
    rst_n = 1'b1;
    chk("rst_ready", int'(move_ready), 1);
    rd(0, 'hA, "rst_sq0");
    rd(60, 6, "rst_sq60");
    rd(28, 0, "rst_sq28");
    rd(4, 'hC, "rst_sq4");
    rd(63, 4, "rst_sq63");
    rd(9, 7, "rst_sq9");

    // from == to on an occupied square
    do_move(52, 52, 2, 1, 0, "same_sq");
    rd(52, 1, "same_sq_b52");

    // e2-e4
    do_move(52, 36, 4, 0, 0, "e2e4");
    rd(36, 1, "e2e4_b36");
    rd(52, 0, "e2e4_b52");

    // empty source
    do_move(20, 28, 2, 1, 0, "empty_src");
    rd(20, 0, "empty_b20");
    rd(28, 0, "empty_b28");

    // empty source onto an occupied square: captured must still be 0
    do_move(20, 0, 2, 1, 0, "err_occ");
    rd(0, 'hA, "err_occ_b0");

    // capture of the black e7 pawn
    do_move(36, 12, 4, 0, 7, "capture");
    rd(12, 1, "cap_b12");
    rd(36, 0, "cap_b36");

    // new_game beats a simultaneous move request
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_from  = 6'd48;
    move_to    = 6'd40;
    #1;
    chk("prio_ready", int'(move_ready), 0);
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    no_done(6, "prio_nodone");
    chk("prio_ready_after", int'(move_ready), 1);
    rd(12, 7, "prio_b12");
    rd(52, 1, "prio_b52");
    rd(36, 0, "prio_b36");
    rd(40, 0, "prio_b40");
    rd(48, 1, "prio_b48");

    // reset while the move is in WR_TO
    move_valid = 1'b1;
    move_from  = 6'd52;
    move_to    = 6'd36;
    tick();
    move_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", int'(move_ready), 1);
    no_done(6, "midrst_nodone");
    rd(36, 0, "midrst_b36");
    rd(52, 1, "midrst_b52");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_move_writer.md
Name: board_move_writer

Overview:
- Owns the 8x8 board state: 64 squares x 4-bit piece code.
- Executes move commands (from-square to to-square) over a valid/ready handshake, and reloads the start position on reset or new game.
- Provides a registered read port with the same square indexing as the figure lookup path, so the renderer can read live board contents.
- Sits between the game/mouse control logic (writer side) and the figure drawing pipeline (reader side).

Parameters:
- CODE_W, 4, piece-code width in bits. Fixed encoding; other values are unsupported.
- SQ_W, 6, square-index width. [5:3] = row (0 = rank 8, 7 = rank 1); [2:0] = column (0 = file a).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- new_game  in  1  reload start position; sampled only in IDLE.
- move_valid  in  1  move request valid.
- move_ready  out  1  move accepted when valid&&ready at a rising edge.
- move_from  in  SQ_W  source square.
- move_to  in  SQ_W  destination square.
- move_done  out  1  one-cycle completion pulse.
- move_err  out  1  valid with move_done; 1 = move rejected, board unchanged.
- move_captured  out  CODE_W  valid with move_done; prior code at move_to (0 if empty or error).
- rd_xy  in  SQ_W  read address.
- rd_code  out  CODE_W  piece code at rd_xy, 1-cycle latency.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Piece codes: 0 empty; white 1 pawn, 2 bishop, 3 knight, 4 rook, 5 queen, 6 king; black 7 pawn, 8 bishop, 9 knight, A rook, B queen, C king; D marker.
- Start position:
  - row0 = A 9 8 B C 8 9 A
  - row1 = all 7
  - rows 2-5 = all 0
  - row6 = all 1
  - row7 = 4 3 2 5 6 2 3 4
- Reset (rst_n=0 at an edge): the whole board loads the start position in parallel in that cycle.
  - State -> IDLE.
  - move_done=0, move_err=0, move_captured=0, rd_code=0.
  - Any in-flight move is abandoned and no done pulse is issued.
- move_ready = (state==IDLE) && !new_game. It is combinational from state and new_game.
- new_game in IDLE: parallel reload of the start position at that edge; state stays IDLE. new_game wins over a simultaneous move_valid, and that move is not accepted. new_game outside IDLE is ignored.
- FSM: IDLE -> RD -> WR_TO -> CLR -> DONE -> IDLE. Error path is RD -> DONE.
  - IDLE: on valid&&ready at edge T, latch from/to; go to RD.
  - RD (cycle T+1): latch piece = board[from] and cap = board[to].
    - If piece==0 or from==to: set err and go to DONE.
    - Otherwise go to WR_TO.
  - WR_TO (T+2): board[to] <= piece.
  - CLR (T+3): board[from] <= 0.
  - DONE: move_done=1 for exactly one cycle.
    - Normal path: DONE is cycle T+4. Error path: DONE is cycle T+2.
    - move_err and move_captured are driven during DONE: captured = cap on success, 0 on error. Both return to 0 the next cycle.
    - move_ready goes high again the cycle after DONE.
- At most one board write per cycle. Move legality, turn order and own-piece capture are not checked; any code at move_to is overwritten and reported in move_captured.
- Read port: rd_code <= board[rd_xy] every edge, including during moves. A write at the same edge is not visible; the old value is returned.
- Inputs move_from/move_to need only be stable in the accept cycle.

Decomposition:
- Shared package (alongside vga_pkg, or a new figure_pkg imported by both sides) holds:
  - piece-code localparams (EMPTY, W_PAWN..B_KING, MARKER)
  - the FSM state enum typedef
  - a square-index typedef (logic [5:0])
- Sub-module board_start_rom: pure combinational, square index -> start-position code. It is used for reset/new_game reload and is reusable by any reader wanting the initial layout.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release. Then rd_xy=0 -> rd_code=A next cycle; rd_xy=60 -> 6; rd_xy=28 -> 0. move_ready=1.
- Quiet move e2-e4 (from=52, to=36), accepted at T:
  - move_ready=0 during T+1..T+4.
  - move_done=1 only at T+4, with err=0 and captured=0.
  - Afterwards rd_xy=36 -> 1 and rd_xy=52 -> 0.
- Error cases:
  - from=20 (empty) to=28: move_done at T+2 with err=1, captured=0; squares 20 and 28 remain 0.
  - from=to=52: err=1, board[52] still 1.
- Capture: after e2-e4, move from=36 to=12. done with captured=7, err=0; then rd 12 -> 1, rd 36 -> 0.
- Priority: in IDLE, drive new_game=1 and move_valid=1 in the same cycle after modifying the board. Then move_ready=0, no done pulse, and squares 36/52 read 0/1 again (start position).
- Reset mid-move: accept 52->36, pull rst_n=0 at T+2.
  - No move_done ever.
  - Board equals start position (36 -> 0, 52 -> 1).
  - move_ready=1 in the first cycle after release.
